bundle_issue_ctrl: RTL and testbench



---
 rtl/vliw_pkg.sv | 20 ++
 rtl/bundle_issue_ctrl_if.sv | 21 ++
 rtl/bundle_issue_ctrl_issue_slot.sv | 41 ++++
 rtl/bundle_issue_ctrl.sv | 106 ++++++++++
 tb/tb_bundle_issue_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vliw_pkg.sv
// Shared VLIW issue types and constants.
// Slot slicing macro picks the 32-bit instruction of slot i from a bundle vector.
`ifndef VLIW_PKG_SV
`define VLIW_PKG_SV
`define VLIW_SLOT(v, i) v[(i)*vliw_pkg::SLOT_W +: vliw_pkg::SLOT_W]

package vliw_pkg;
  localparam int SLOT_W = 32;
  localparam int NUM_FU_DEF = 4;
  localparam int BUNDLE_BYTES_DEF = NUM_FU_DEF * 4;
  localparam int ACK_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RETIRE
  } issue_state_t;
endpackage
`endif

// File: rtl/bundle_issue_ctrl_if.sv
// Fetch-to-issue bundle handshake.
// Fetch is the master; the issue controller is the slave.
interface bundle_issue_ctrl_if #(
  parameter int NUM_FU = 4
);
  logic                 bundle_valid;
  logic                 bundle_ready;
  logic [63:0]          bundle_addr;
  logic [32*NUM_FU-1:0] bundle_insn;
  logic [NUM_FU-1:0]    slot_mask;

  modport master (
    output bundle_valid, bundle_addr, bundle_insn, slot_mask,
    input  bundle_ready
  );

  modport slave (
    input  bundle_valid, bundle_addr, bundle_insn, slot_mask,
    output bundle_ready
  );
endinterface

// File: rtl/bundle_issue_ctrl_issue_slot.sv
// One bundle slot: instruction latch, enable bit, acked bit
// and instructionReady strobe for its functional unit.
module issue_slot
  import vliw_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [SLOT_W-1:0] insn_in,
  input  logic              mask_in,
  input  logic              issue,
  input  logic              force_ack,
  input  logic              working,
  output logic [SLOT_W-1:0] instruction,
  output logic              mask,
  output logic              ready,
  output logic              done
);
  logic acked;

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
      mask        <= 1'b0;
      acked       <= 1'b0;
    end else if (load) begin
      instruction <= insn_in;
      mask        <= mask_in;
      acked       <= 1'b0;
    end else if (issue) begin
      if (force_ack)
        acked <= mask;
      else if (mask && working)
        acked <= 1'b1;
    end
  end

  assign ready = issue && mask && !acked;
  // done counts this cycle's working sample so ISSUE exits on the ack edge
  assign done = !mask || acked || working;
endmodule

// File: rtl/bundle_issue_ctrl.sv
// Bundle issue sequencer: issues enabled slots, waits for retire,
// publishes the next fetch address and tracks ack timeouts.
module bundle_issue_ctrl
  import vliw_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int BUNDLE_BYTES = BUNDLE_BYTES_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
)(
  input  logic                     clk,
  input  logic                     rst,
  bundle_issue_ctrl_if.slave       bus,
  output logic [SLOT_W*NUM_FU-1:0] fu_instruction,
  output logic [63:0]              fu_bundle_addr,
  output logic [NUM_FU-1:0]        fu_instruction_ready,
  input  logic [NUM_FU-1:0]        fu_working,
  output logic [NUM_FU-1:0]        fu_stall,
  input  logic                     ext_stall,
  output logic [63:0]              next_addr,
  output logic                     next_addr_valid,
  output logic                     issue_timeout,
  output logic [31:0]              retired_count
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  issue_state_t      state, state_n;
  logic [CW-1:0]     cnt;
  logic [63:0]       addr_q;
  logic [NUM_FU-1:0] mask, done;
  logic              accept, issue, timeout_hit;

  assign fu_stall        = {NUM_FU{ext_stall}};
  assign bus.bundle_ready = (state == IDLE) && !ext_stall && !rst;
  assign accept          = bus.bundle_valid && bus.bundle_ready;
  assign issue           = (state == ISSUE) && !ext_stall;
  assign next_addr_valid = (state == RETIRE) && !ext_stall;
  assign fu_bundle_addr  = addr_q;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    issue_slot u_slot (
      .clk         (clk),
      .rst         (rst),
      .load        (accept),
      .insn_in     (`VLIW_SLOT(bus.bundle_insn, g)),
      .mask_in     (bus.slot_mask[g]),
      .issue       (issue),
      .force_ack   (timeout_hit),
      .working     (fu_working[g]),
      .instruction (`VLIW_SLOT(fu_instruction, g)),
      .mask        (mask[g]),
      .ready       (fu_instruction_ready[g]),
      .done        (done[g])
    );
  end

  always_comb begin
    state_n     = state;
    timeout_hit = 1'b0;
    if (!ext_stall) begin
      unique case (state)
        IDLE:
          if (accept)
            state_n = (|bus.slot_mask) ? ISSUE : RETIRE;
        ISSUE:
          if (&done) begin
            state_n = WAIT_DONE;
          end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
            timeout_hit = 1'b1;
            state_n     = WAIT_DONE;
          end
        WAIT_DONE:
          if ((fu_working & mask) == '0)
            state_n = RETIRE;
        RETIRE:
          state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      next_addr     <= '0;
      issue_timeout <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= bus.bundle_addr;
        cnt    <= '0;
      end else if (issue) begin
        cnt <= cnt + 1'b1;
      end
      if (timeout_hit)
        issue_timeout <= 1'b1;
      // zero-mask bundles retire before addr_q is visible
      if (state_n == RETIRE && state != RETIRE)
        next_addr <= ((state == IDLE) ? bus.bundle_addr : addr_q)
                     + 64'(BUNDLE_BYTES);
      if (next_addr_valid)
        retired_count <= retired_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_bundle_issue_ctrl.sv
// Self-checking bench for bundle_issue_ctrl with behavioural FU models
// and a latency/address reference derived from the bundle rules.
module tb_bundle_issue_ctrl;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N*32-1:0] fu_instruction;
  logic [63:0] fu_bundle_addr;
  logic [N-1:0] fu_instruction_ready;
  logic [N-1:0] fu_working;
  logic [N-1:0] fu_stall;
  logic ext_stall;
  logic [63:0] next_addr;
  logic next_addr_valid;
  logic issue_timeout;
  logic [31:0] retired_count;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  logic [N-1:0] dead = '0;
  logic [N-1:0] stuck = '0;
  int busy [N];

  bundle_issue_ctrl_if #(.NUM_FU(N)) bus();

  bundle_issue_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .fu_instruction       (fu_instruction),
    .fu_bundle_addr       (fu_bundle_addr),
    .fu_instruction_ready (fu_instruction_ready),
    .fu_working           (fu_working),
    .fu_stall             (fu_stall),
    .ext_stall            (ext_stall),
    .next_addr            (next_addr),
    .next_addr_valid      (next_addr_valid),
    .issue_timeout        (issue_timeout),
    .retired_count        (retired_count)
  );

  always #5 clk = ~clk;

  // FU model: takes an instruction and stays working for 3 cycles
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst)
        busy[i] <= 0;
      else if (!fu_stall[i]) begin
        if (busy[i] > 0)
          busy[i] <= busy[i] - 1;
        else if (fu_instruction_ready[i] && !dead[i])
          busy[i] <= 3;
      end
    end
  end

  always_comb begin
    fu_working = stuck;
    for (int i = 0; i < N; i++)
      if (busy[i] > 0) fu_working[i] = 1'b1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_bundle(
    input  logic [63:0]    a,
    input  logic [N*32-1:0] ins,
    input  logic [N-1:0]   m,
    input  int             s_at,
    input  int             s_len,
    output int             lat,
    output logic [N-1:0]   strobed,
    output logic [63:0]    na,
    output logic           stall_all,
    output logic           nav_stalled,
    output logic           acc_ok,
    output int             tmo_k
  );
    int w;
    lat = -1;
    strobed = '0;
    na = '0;
    stall_all = 1'b1;
    nav_stalled = 1'b0;
    tmo_k = -1;
    bus.bundle_valid = 1'b1;
    bus.bundle_addr = a;
    bus.bundle_insn = ins;
    bus.slot_mask = m;
    ext_stall = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus.bundle_ready && w < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    acc_ok = bus.bundle_ready;
    @(posedge clk); #1;
    bus.bundle_valid = 1'b0;
    for (int k = 1; k < 80; k++) begin
      ext_stall = (k >= s_at) && (k < s_at + s_len);
      @(negedge clk);
      strobed |= fu_instruction_ready;
      if (issue_timeout && tmo_k < 0) tmo_k = k;
      if (ext_stall) begin
        stall_all &= (fu_stall == {N{1'b1}});
        nav_stalled |= next_addr_valid;
      end else if (next_addr_valid) begin
        lat = k;
        na = next_addr;
        break;
      end
      @(posedge clk); #1;
    end
    ext_stall = 1'b0;
    if (lat > 0) exp_ret++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    ext_stall = 1'b0;
    bus.bundle_valid = 1'b0;
    bus.bundle_addr = '0;
    bus.bundle_insn = '0;
    bus.slot_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.bundle_ready, fu_instruction, fu_bundle_addr, fu_instruction_ready,
         fu_stall, next_addr, next_addr_valid, issue_timeout, retired_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b ins=%h ba=%h ir=%b st=%b na=%h nav=%b to=%b rc=%0d exp=all_zero",
               bus.bundle_ready, fu_instruction, fu_bundle_addr, fu_instruction_ready,
               fu_stall, next_addr, next_addr_valid, issue_timeout, retired_count);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.bundle_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got=%b exp=1", bus.bundle_ready);
    end
  endtask

  task automatic test_full;
    int lat, tk;
    logic [N-1:0] sb;
    logic [63:0] na;
    logic sa, ns, ok;
    logic [N*32-1:0] ins;
    ins = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
    run_bundle(64'h1000, ins, 4'b1111, 0, 0, lat, sb, na, sa, ns, ok, tk);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL full_latency got=%0d exp=6", lat);
    end
    checks++;
    if (na !== 64'h1010) begin
      failures++;
      $display("FAIL full_next_addr got=%h exp=1010", na);
    end
    checks++;
    if (sb !== 4'b1111) begin
      failures++;
      $display("FAIL full_strobed got=%b exp=1111", sb);
    end
    checks++;
    if (fu_instruction !== ins || fu_bundle_addr !== 64'h1000) begin
      failures++;
      $display("FAIL full_latch got=%h/%h exp=%h/1000", fu_instruction, fu_bundle_addr, ins);
    end
    checks++;
    if (retired_count !== 32'd1) begin
      failures++;
      $display("FAIL full_retired got=%0d exp=1", retired_count);
    end
    checks++;
    if (bus.bundle_ready !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_ready got=%b exp=1", bus.bundle_ready);
    end
  endtask

  task automatic test_partial_mask;
    int lat, tk;
    logic [N-1:0] sb;
    logic [63:0] na;
    logic sa, ns, ok;
    stuck = 4'b1010;
    run_bundle(64'h2000, {4{32'hABCD_0013}}, 4'b0101, 0, 0, lat, sb, na, sa, ns, ok, tk);
    stuck = '0;
    checks++;
    if (sb !== 4'b0101) begin
      failures++;
      $display("FAIL partial_strobed got=%b exp=0101", sb);
    end
    checks++;
    if (lat !== 6 || na !== 64'h2010) begin
      failures++;
      $display("FAIL partial_retire got=%0d/%h exp=6/2010", lat, na);
    end
    checks++;
    if (retired_count !== 32'(exp_ret)) begin
      failures++;
      $display("FAIL partial_retired got=%0d exp=%0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_zero_mask_wrap;
    int lat, tk;
    logic [N-1:0] sb;
    logic [63:0] na;
    logic sa, ns, ok;
    run_bundle(64'hFFFF_FFFF_FFFF_FFF0, '0, 4'b0000, 0, 0, lat, sb, na, sa, ns, ok, tk);
    checks++;
    if (lat !== 1 || na !== 64'h0) begin
      failures++;
      $display("FAIL zero_mask got=%0d/%h exp=1/0", lat, na);
    end
    checks++;
    if (sb !== 4'b0000) begin
      failures++;
      $display("FAIL zero_strobed got=%b exp=0000", sb);
    end
  endtask

  task automatic test_stall_wait;
    int lat, tk;
    logic [N-1:0] sb;
    logic [63:0] na;
    logic sa, ns, ok;
    run_bundle(64'h3000, '1, 4'b1111, 3, 3, lat, sb, na, sa, ns, ok, tk);
    checks++;
    if (lat !== 9) begin
      failures++;
      $display("FAIL stall_latency got=%0d exp=9", lat);
    end
    checks++;
    if (sa !== 1'b1) begin
      failures++;
      $display("FAIL stall_fanout got=%b exp=1", sa);
    end
    checks++;
    if (ns !== 1'b0) begin
      failures++;
      $display("FAIL stall_pulse got=%b exp=0", ns);
    end
    checks++;
    if (na !== 64'h3010) begin
      failures++;
      $display("FAIL stall_next_addr got=%h exp=3010", na);
    end
  endtask

  task automatic test_timeout;
    int lat, tk;
    logic [N-1:0] sb;
    logic [63:0] na;
    logic sa, ns, ok;
    dead = 4'b0100;
    run_bundle(64'h4000, '0, 4'b1111, 0, 0, lat, sb, na, sa, ns, ok, tk);
    dead = '0;
    checks++;
    if (tk !== 16) begin
      failures++;
      $display("FAIL timeout_first_seen got=%0d exp=16", tk);
    end
    checks++;
    if (lat !== 17 || na !== 64'h4010) begin
      failures++;
      $display("FAIL timeout_retire got=%0d/%h exp=17/4010", lat, na);
    end
    run_bundle(64'h5000, '0, 4'b0011, 0, 0, lat, sb, na, sa, ns, ok, tk);
    checks++;
    if (issue_timeout !== 1'b1 || lat !== 6) begin
      failures++;
      $display("FAIL timeout_sticky got=%b/%0d exp=1/6", issue_timeout, lat);
    end
    checks++;
    if (retired_count !== 32'(exp_ret)) begin
      failures++;
      $display("FAIL timeout_retired got=%0d exp=%0d", retired_count, exp_ret);
    end
  endtask

  task automatic test_reset_mid;
    bus.bundle_valid = 1'b1;
    bus.bundle_addr = 64'h6000;
    bus.bundle_insn = '1;
    bus.slot_mask = 4'b1111;
    ext_stall = 1'b0;
    @(posedge clk); #1;
    bus.bundle_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.bundle_ready, fu_instruction, fu_bundle_addr, fu_instruction_ready,
         next_addr, next_addr_valid, issue_timeout, retired_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid got ready=%b ins=%h ba=%h ir=%b na=%h nav=%b to=%b rc=%0d exp=all_zero",
               bus.bundle_ready, fu_instruction, fu_bundle_addr, fu_instruction_ready,
               next_addr, next_addr_valid, issue_timeout, retired_count);
    end
    rst = 1'b0;
    exp_ret = 0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int lat, tk, base, s_at, s_len, exp_lat;
    logic [N-1:0] sb, m;
    logic [63:0] na, a;
    logic sa, ns, ok;
    logic [N*32-1:0] ins;
    for (int t = 0; t < 16; t++) begin
      m = N'($urandom);
      a = {$urandom, $urandom};
      ins = {$urandom, $urandom, $urandom, $urandom};
      stuck = N'($urandom) & ~m;
      base = (m == '0) ? 1 : 6;
      s_at = $urandom_range(base, 1);
      s_len = $urandom_range(3, 0);
      exp_lat = base + s_len;
      run_bundle(a, ins, m, s_at, s_len, lat, sb, na, sa, ns, ok, tk);
      stuck = '0;
      checks++;
      if (lat !== exp_lat || na !== a + 64'd16) begin
        failures++;
        $display("FAIL rand%0d_retire got=%0d/%h exp=%0d/%h", t, lat, na, exp_lat, a + 64'd16);
      end
      checks++;
      if (sb !== m || ns !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_strobe got=%b/%b exp=%b/0", t, sb, ns, m);
      end
      checks++;
      if (fu_instruction !== ins || fu_bundle_addr !== a) begin
        failures++;
        $display("FAIL rand%0d_latch got=%h/%h exp=%h/%h", t, fu_instruction, fu_bundle_addr, ins, a);
      end
      checks++;
      if (retired_count !== 32'(exp_ret) || issue_timeout !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_count got=%0d/%b exp=%0d/0", t, retired_count, issue_timeout, exp_ret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_partial_mask();
    test_zero_mask_wrap();
    test_stall_wait();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
